// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with a registered one-hot grant that parks on master 0 when the bus is idle.
// Define ARB_TIMEOUT_EN to compile in the hold counter that forces rotation after MAX_HOLD cycles under contention.
module bus_arbiter_rr #(
  parameter  int NUM_MASTERS = 4,
  parameter  int MAX_HOLD    = 16,
  localparam int ID_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   grant_chg
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num_masters
    $error("bus_arbiter_rr: NUM_MASTERS out of range 2..16");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter_rr: MAX_HOLD out of range 2..255");
  end

  logic [ID_W-1:0] rot_id;
  logic            rot_found;
  logic            force_rot;
  logic [ID_W-1:0] nxt_id;
  logic            owner_chg;
  int              idx;

  // First requester after the current owner, wrapping; the owner itself is never a candidate here.
  always_comb begin
    rot_id    = grant_id;
    rot_found = 1'b0;
    idx       = 0;
    for (int k = 1; k < NUM_MASTERS; k++) begin
      idx = int'(grant_id) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!rot_found && req[idx]) begin
        rot_found = 1'b1;
        rot_id    = ID_W'(idx);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  always_comb begin
    force_rot = (hold_cnt == 8'(MAX_HOLD - 1)) && req[grant_id] && ((req & ~grant) != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= 8'd0;
    end else if (owner_chg) begin
      hold_cnt <= 8'd0;
    end else if (hold_cnt < 8'(MAX_HOLD - 1)) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  always_comb begin
    force_rot = 1'b0;
  end
`endif

  always_comb begin
    nxt_id = grant_id;
    if (req == '0) begin
      nxt_id = '0;
    end else if (req[grant_id] && !force_rot) begin
      nxt_id = grant_id;
    end else if (rot_found) begin
      nxt_id = rot_id;
    end
    owner_chg = (nxt_id != grant_id);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant     <= NUM_MASTERS'(1);
      grant_id  <= '0;
      grant_chg <= 1'b0;
    end else begin
      grant     <= NUM_MASTERS'(1) << nxt_id;
      grant_id  <= nxt_id;
      grant_chg <= owner_chg;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr (NUM_MASTERS=4, MAX_HOLD=4) against a behavioural round-robin model.
module tb_bus_arbiter_rr;
  localparam int NM = 4;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NM-1:0] req = '0;
  logic [NM-1:0] grant;
  logic [1:0]    grant_id;
  logic          grant_chg;

  int total = 0;
  int bad   = 0;

  int m_owner = 0;
  int m_hold  = 0;
  bit m_chg   = 0;

  bus_arbiter_rr #(.NUM_MASTERS(NM), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .grant(grant), .grant_id(grant_id), .grant_chg(grant_chg)
  );

  always #5 clk = ~clk;

  // Owner sequence derived directly from the arbitration rules.
  task automatic model_step(input logic [NM-1:0] r);
    int nxt;
    bit force_rot;
    force_rot = 0;
`ifdef ARB_TIMEOUT_EN
    force_rot = (m_hold == MH - 1) && r[m_owner] && ((r & ~(NM'(1) << m_owner)) != 0);
`endif
    if (r == 0) nxt = 0;
    else if (r[m_owner] && !force_rot) nxt = m_owner;
    else begin
      nxt = m_owner;
      for (int k = 1; k <= NM; k++) begin
        if (r[(m_owner + k) % NM]) begin
          nxt = (m_owner + k) % NM;
          break;
        end
      end
    end
    m_chg   = (nxt != m_owner);
    m_hold  = m_chg ? 0 : ((m_hold < MH - 1) ? m_hold + 1 : m_hold);
    m_owner = nxt;
  endtask

  task automatic step(input logic [NM-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_owner = 0; m_hold = 0; m_chg = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({grant, grant_id, grant_chg} !== {4'b0001, 2'd0, 1'b0}) begin
      bad++; $display("FAIL reset_release got=%b/%0d/%b want=0001/0/0", grant, grant_id, grant_chg);
    end
    step(4'b0100);
    total++;
    if (grant !== 4'b0100 || grant_chg !== 1'b1) begin
      bad++; $display("FAIL reset_setup_owner2 got=%b/%b want=0100/1", grant, grant_chg);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({grant, grant_id, grant_chg} !== {4'b0001, 2'd0, 1'b0}) begin
      bad++; $display("FAIL reset_async got=%b/%0d/%b want=0001/0/0", grant, grant_id, grant_chg);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_owner = 0; m_hold = 0; m_chg = 0;
  endtask

  task automatic test_handoff_park();
    logic [NM-1:0] rs [4] = '{4'b0001, 4'b1010, 4'b1000, 4'b0000};
    logic [NM-1:0] eg [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    bit            ec [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(rs[i]);
      total++;
      if (grant !== eg[i] || grant_chg !== ec[i]) begin
        bad++; $display("FAIL handoff_park[%0d] got=%b/%b want=%b/%b", i, grant, grant_chg, eg[i], ec[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(4'b1000);
    step(4'b1000);
    step(4'b0101);
    total++;
    if (grant !== 4'b0001 || grant_id !== 2'd0 || grant_chg !== 1'b1) begin
      bad++; $display("FAIL wrap got=%b/%0d/%b want=0001/0/1", grant, grant_id, grant_chg);
    end
  endtask

  task automatic test_hold();
    int errs;
    do_reset();
    step(4'b0010);
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      step(4'b0010);
      if (grant !== 4'b0010 || grant_chg !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL hold_single errors=%0d want=0 last=%b/%b", errs, grant, grant_chg);
    end
  endtask

  task automatic test_timeout();
    logic [NM-1:0] exp_g;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      step(4'b0011);
`ifdef ARB_TIMEOUT_EN
      exp_g = (((e / MH) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
      exp_g = 4'b0001;
`endif
      total++;
      if (grant !== exp_g) begin
        bad++; $display("FAIL timeout edge%0d got=%b want=%b", e, grant, exp_g);
      end
    end
  endtask

  task automatic test_timeout_boundary();
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0001);
      if (grant !== 4'b0001 || grant_chg !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL timeout_boundary errors=%0d want=0 last=%b", errs, grant);
    end
  endtask

  task automatic test_random();
    logic [NM-1:0] r;
    do_reset();
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) r = NM'($urandom_range(0, 15));
      step(r);
      total++;
      if (grant !== (NM'(1) << m_owner) || grant_id !== 2'(m_owner) || grant_chg !== m_chg) begin
        bad++;
        $display("FAIL random[%0d] req=%b got=%b/%0d/%b want=%b/%0d/%b", i, r, grant, grant_id,
                 grant_chg, NM'(1) << m_owner, m_owner, m_chg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_handoff_park();
    test_wrap();
    test_hold();
    test_timeout();
    test_timeout_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting masters; legal range 2..16.
REQ-002 SHALL have parameter MAX_HOLD, default 16, maximum consecutive grant cycles under contention; legal range 2..255; used only when ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have derived localparam ID_W = max(1, ceil(log2(NUM_MASTERS))).
REQ-004 SHALL have port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, NUM_MASTERS bits: bit i high means master i requests the bus.
REQ-007 SHALL have port grant, output, NUM_MASTERS bits: registered one-hot grant; bit i high means master i owns the bus.
REQ-008 SHALL have port grant_id, output, ID_W bits: registered binary index of the set bit in grant.
REQ-009 SHALL have port grant_chg, output, 1 bit: registered one-cycle pulse in the cycle the owner differs from the previous cycle's owner.

Function
REQ-010 SHALL keep grant exactly one-hot at all times; it is never all-zero.
REQ-011 SHALL keep grant_id consistent with grant in every cycle.
REQ-012 SHALL update grant, grant_id and grant_chg only on rising clk, one cycle after the req value sampled on that edge.
REQ-013 SHALL keep the current owner (no change) when req[owner] = 1, subject to REQ-017.
REQ-014 SHALL, when req[owner] = 0 and req != 0, grant the first requesting master in the search order owner+1, owner+2, ..., wrapping modulo NUM_MASTERS.
REQ-015 SHALL, when req = 0, park the grant on master 0; if the owner is already 0, nothing changes.
REQ-016 SHALL set grant_chg = 1 for exactly one cycle on an edge that changes the owner, including a change to park; otherwise grant_chg = 0.
REQ-017 SHALL, with ARB_TIMEOUT_EN defined, force rotation per REQ-014 on an edge where hold_cnt = MAX_HOLD-1, req[owner] = 1, and at least one other req bit is high.
REQ-018 SHALL hold no master for more than MAX_HOLD consecutive cycles while others request, with ARB_TIMEOUT_EN defined.
REQ-019 SHALL implement hold_cnt as an internal 8-bit counter with the following behaviour:
- cleared on reset and on every owner change;
- incremented on each edge the owner is kept;
- saturates at MAX_HOLD-1.
REQ-020 SHALL treat req bits of non-owners changing in the same cycle the owner drops as sampled on that edge; there is no priority to earlier requesters.

Reset
REQ-021 SHALL, while reset_n = 0 and independent of clk, set outputs and internal state as follows:
- grant = 1 (master 0);
- grant_id = 0;
- grant_chg = 0;
- hold_cnt = 0.
REQ-022 SHALL apply REQ-021 immediately on reset assertion during any grant, including mid-timeout count.
REQ-023 SHALL resume arbitration per REQ-013..REQ-015 on the first rising clk after reset_n deasserts, with owner 0 as the starting point.

Configuration
REQ-024 SHALL have macro ARB_TIMEOUT_EN; when defined, the hold counter and forced rotation of REQ-017..REQ-019 are compiled in.
REQ-025 SHALL, when ARB_TIMEOUT_EN is undefined, contain no hold counter logic, so an owner with req held high keeps the bus indefinitely; MAX_HOLD is ignored.

Verification (NUM_MASTERS=4, MAX_HOLD=4)
REQ-026 SHALL cover reset: drive reset_n=0 with owner 2 and no clk edge -> grant=4'b0001, grant_id=0, grant_chg=0 immediately.
REQ-027 SHALL cover hand-off and park: owner 0 with req=4'b0001, then req=4'b1010 -> grant=4'b0010 with grant_chg pulse; then req=4'b1000 -> grant=4'b1000; then req=0 -> grant=4'b0001 with grant_chg pulse.
REQ-028 SHALL cover wrap-around: owner 3, req changes 4'b1000 -> 4'b0101 -> next edge grant=4'b0001, grant_id=0.
REQ-029 SHALL cover hold: owner 1 with req=4'b0010 held for 50 cycles, macro undefined -> grant stays 4'b0010, grant_chg stays 0.
REQ-030 SHALL cover timeout: ARB_TIMEOUT_EN defined, req=4'b0011 constant from reset release -> grant=4'b0001 for 4 cycles, then 4'b0010 for 4 cycles, then 4'b0001, alternating.
REQ-031 SHALL cover the timeout boundary: ARB_TIMEOUT_EN defined, req=4'b0001 only for 20 cycles -> no rotation, grant=4'b0001 throughout.
